int_sequencer: RTL and testbench

Interrupt sequencer for the single-cycle/pipelined MIPS core. It latches external interrupt requests and arbitrates them by fixed priority. At an instruction boundary it drives the CP0 register file through a fixed multi-cycle sequence: save EPC, write Cause, clear IE, redirect the PC to the handler vector. It also sequences ERET: read EPC, set IE, redirect. It sits between the pipeline control, the PC mux and the CP0 write/read/IE-control ports, and stalls the pipeline while sequencing.

---
 rtl/int_sequencer.sv | 163 ++++++++++++++++
 tb/tb_int_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt sequencer: captures irq rising edges, arbitrates by fixed priority and
// walks CP0 through the EPC/Cause/IE/vector entry sequence and the ERET return sequence.
module int_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [2:0]       irq,
  input  logic             boundary,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             eret,
  input  logic             ie,
  input  logic [WIDTH-1:0] cp0_rdata,
  output logic             cp0_we,
  output logic [4:0]       cp0_waddr,
  output logic [WIDTH-1:0] cp0_wdata,
  output logic [4:0]       cp0_raddr,
  output logic             ie_one,
  output logic             ie_zero,
  output logic             stall,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [2:0]       pending
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SAVE_EPC   = 3'd1,
    S_SAVE_CAUSE = 3'd2,
    S_MASK       = 3'd3,
    S_VECTOR     = 3'd4,
    S_RESTORE    = 3'd5,
    S_RETURN     = 3'd6
  } state_t;

  state_t           state_reg;
  logic [2:0]       irq_q_reg;
  logic [2:0]       pending_reg;
  logic [1:0]       idx_reg;
  logic             cp0_we_reg;
  logic [4:0]       cp0_waddr_reg;
  logic [WIDTH-1:0] cp0_wdata_reg;
  logic [4:0]       cp0_raddr_reg;
  logic             ie_one_reg;
  logic             ie_zero_reg;
  logic             stall_reg;
  logic             redirect_reg;
  logic [WIDTH-1:0] redirect_pc_reg;

  logic             take;
  logic [1:0]       idx_c;
  logic [2:0]       clr_mask;
  logic [2:0]       rise;
  logic [2:0]       pending_next;
  logic [WIDTH-1:0] cause_word;
  logic [WIDTH-1:0] vec_addr;

  assign rise = irq & ~irq_q_reg;
  assign take = (state_reg == S_IDLE) & ~eret & boundary & ie & (pending_reg != 3'b000);

  always_comb begin
    idx_c = 2'd0;
    if (pending_reg[0])      idx_c = 2'd0;
    else if (pending_reg[1]) idx_c = 2'd1;
    else if (pending_reg[2]) idx_c = 2'd2;
  end

  // New edges are OR'd in after the take clear so a coincident set wins.
  assign clr_mask     = take ? (3'b001 << idx_c) : 3'b000;
  assign pending_next = (pending_reg & ~clr_mask) | rise;

  assign cause_word = {{(WIDTH-1){1'b0}}, 1'b1} << (5'd8 + {3'b000, idx_reg});
  assign vec_addr   = VEC_BASE + ({{(WIDTH-2){1'b0}}, idx_reg} * VEC_STRIDE);

  // Outputs are registered on entry to each state, so every state's outputs are
  // loaded on the transition into it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg       <= S_IDLE;
      irq_q_reg       <= 3'b000;
      pending_reg     <= 3'b000;
      idx_reg         <= 2'd0;
      cp0_we_reg      <= 1'b0;
      cp0_waddr_reg   <= 5'd0;
      cp0_wdata_reg   <= '0;
      cp0_raddr_reg   <= 5'd0;
      ie_one_reg      <= 1'b0;
      ie_zero_reg     <= 1'b0;
      stall_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      irq_q_reg       <= irq;
      pending_reg     <= pending_next;
      cp0_we_reg      <= 1'b0;
      cp0_waddr_reg   <= 5'd0;
      cp0_wdata_reg   <= '0;
      cp0_raddr_reg   <= 5'd0;
      ie_one_reg      <= 1'b0;
      ie_zero_reg     <= 1'b0;
      stall_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (eret) begin
            state_reg     <= S_RESTORE;
            stall_reg     <= 1'b1;
            cp0_raddr_reg <= 5'd14;
          end else if (take) begin
            state_reg     <= S_SAVE_EPC;
            idx_reg       <= idx_c;
            stall_reg     <= 1'b1;
            cp0_we_reg    <= 1'b1;
            cp0_waddr_reg <= 5'd14;
            cp0_wdata_reg <= pc_next;
          end
        end
        S_SAVE_EPC: begin
          state_reg     <= S_SAVE_CAUSE;
          stall_reg     <= 1'b1;
          cp0_we_reg    <= 1'b1;
          cp0_waddr_reg <= 5'd13;
          cp0_wdata_reg <= cause_word;
        end
        S_SAVE_CAUSE: begin
          state_reg   <= S_MASK;
          stall_reg   <= 1'b1;
          ie_zero_reg <= 1'b1;
        end
        S_MASK: begin
          state_reg       <= S_VECTOR;
          stall_reg       <= 1'b1;
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= vec_addr;
        end
        S_RESTORE: begin
          // The redirect register doubles as the captured return address.
          state_reg       <= S_RETURN;
          stall_reg       <= 1'b1;
          ie_one_reg      <= 1'b1;
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= cp0_rdata;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cp0_we      = cp0_we_reg;
  assign cp0_waddr   = cp0_waddr_reg;
  assign cp0_wdata   = cp0_wdata_reg;
  assign cp0_raddr   = cp0_raddr_reg;
  assign ie_one      = ie_one_reg;
  assign ie_zero     = ie_zero_reg;
  assign stall       = stall_reg | take;
  assign redirect    = redirect_reg;
  assign redirect_pc = redirect_pc_reg;
  assign pending     = pending_reg;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-of-frames reference model.
module tb_int_sequencer;

  logic        clk;
  logic        clr_n;
  logic [2:0]  irq;
  logic        boundary;
  logic [31:0] pc_next;
  logic        eret;
  logic        ie;
  logic [31:0] cp0_rdata;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic        ie_one;
  logic        ie_zero;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  pending;

  logic [31:0] cp0_epc_tb;
  int          n_checks;
  int          n_fail;

  int_sequencer dut (
    .clk(clk), .clr_n(clr_n), .irq(irq), .boundary(boundary), .pc_next(pc_next),
    .eret(eret), .ie(ie), .cp0_rdata(cp0_rdata), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .ie_one(ie_one), .ie_zero(ie_zero),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal CP0: only EPC (reg 14) is readable with a bench-chosen value.
  assign cp0_rdata = (cp0_raddr == 5'd14) ? cp0_epc_tb : 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [78:0] v;
    logic        ret;
    logic        restore;
  } frame_t;

  frame_t      m_q[$];
  logic [2:0]  m_pend;
  logic [2:0]  m_prev;
  logic [31:0] m_ret;

  logic [81:0] obs_vec;
  logic [81:0] exp_vec;
  logic        s_stall, s_redirect, s_we, s_ie_one, s_ie_zero;
  logic [4:0]  s_waddr, s_raddr;
  logic [31:0] s_wdata, s_rpc;
  logic [2:0]  s_pend;

  function automatic logic [78:0] mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                     input logic [4:0] ra, input logic i1, input logic i0,
                                     input logic st, input logic rd, input logic [31:0] rpc);
    return {we, wa, wd, ra, i1, i0, st, rd, rpc};
  endfunction

  function automatic logic model_take();
    return (m_q.size() == 0) && !eret && boundary && ie && (m_pend != 3'b000);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend = 3'b000;
    m_prev = 3'b000;
    m_ret  = 32'h0;
  endtask

  task automatic model_expect();
    logic [78:0] v;
    if (m_q.size() != 0) begin
      v = m_q[0].v;
      if (m_q[0].ret) v[31:0] = m_ret;
    end else begin
      v = mk(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, model_take(), 1'b0, 32'h0);
    end
    exp_vec = {v, m_pend};
  endtask

  task automatic model_advance();
    logic [2:0] rise;
    frame_t f;
    int sel;
    rise = irq & ~m_prev;
    m_prev = irq;
    if (m_q.size() != 0) begin
      f = m_q.pop_front();
      if (f.restore) m_ret = cp0_epc_tb;
    end else if (eret) begin
      m_q.push_back('{mk(0, 5'd0, 32'h0, 5'd14, 0, 0, 1, 0, 32'h0), 1'b0, 1'b1});
      m_q.push_back('{mk(0, 5'd0, 32'h0, 5'd0, 1, 0, 1, 1, 32'h0), 1'b1, 1'b0});
    end else if (model_take()) begin
      sel = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
      m_pend[sel] = 1'b0;
      m_q.push_back('{mk(1, 5'd14, pc_next, 5'd0, 0, 0, 1, 0, 32'h0), 1'b0, 1'b0});
      m_q.push_back('{mk(1, 5'd13, 32'h1 << (8 + sel), 5'd0, 0, 0, 1, 0, 32'h0), 1'b0, 1'b0});
      m_q.push_back('{mk(0, 5'd0, 32'h0, 5'd0, 0, 1, 1, 0, 32'h0), 1'b0, 1'b0});
      m_q.push_back('{mk(0, 5'd0, 32'h0, 5'd0, 0, 0, 1, 1, 32'h3000 + 32'(sel) * 32'h10), 1'b0, 1'b0});
    end
    m_pend = m_pend | rise;
  endtask

  // One clock: sample outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    obs_vec = {cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ie_one, ie_zero, stall, redirect,
               redirect_pc, pending};
    s_stall = stall; s_redirect = redirect; s_rpc = redirect_pc; s_we = cp0_we;
    s_waddr = cp0_waddr; s_wdata = cp0_wdata; s_raddr = cp0_raddr; s_pend = pending;
    s_ie_one = ie_one; s_ie_zero = ie_zero;
    model_expect();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #3;
    model_reset();
    clr_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    irq = 3'b001; boundary = 1'b0; ie = 1'b0; eret = 1'b0; pc_next = 32'h0; cp0_epc_tb = 32'h0;
    clr_n = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if ({cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ie_one, ie_zero, stall, redirect, redirect_pc, pending} !== 82'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ie_one, ie_zero, stall, redirect, redirect_pc, pending});
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec); end
    end
    n_checks++;
    if (pending !== 3'b001) begin n_fail++; $display("FAIL reset_high_line_edge: got %b want 001", pending); end
    irq = 3'b000;
    do_reset();
  endtask

  task automatic test_single_irq();
    int stall_cnt = 0;
    logic [31:0] rpc_seen = 32'h0, cause_seen = 32'h0, epc_seen = 32'h0;
    ie = 1'b1; boundary = 1'b1; pc_next = 32'h0000_0040;
    irq = 3'b010;
    for (int i = 0; i < 8; i++) begin
      step();
      irq = 3'b000;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL single_irq cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_stall) stall_cnt++;
      if (s_redirect) rpc_seen = s_rpc;
      if (s_we && s_waddr == 5'd13) cause_seen = s_wdata;
      if (s_we && s_waddr == 5'd14) epc_seen = s_wdata;
    end
    n_checks += 5;
    if (stall_cnt != 5) begin n_fail++; $display("FAIL single_stall_len: got %0d want 5", stall_cnt); end
    if (rpc_seen !== 32'h0000_3010) begin n_fail++; $display("FAIL single_vector: got %h want 00003010", rpc_seen); end
    if (cause_seen !== 32'h0000_0200) begin n_fail++; $display("FAIL single_cause: got %h want 00000200", cause_seen); end
    if (epc_seen !== 32'h0000_0040) begin n_fail++; $display("FAIL single_epc: got %h want 00000040", epc_seen); end
    if (pending !== 3'b000) begin n_fail++; $display("FAIL single_pending: got %b want 000", pending); end
  endtask

  task automatic test_priority();
    logic [31:0] rpcs[$];
    logic [31:0] first_cause = 32'h0;
    ie = 1'b1; boundary = 1'b1; pc_next = 32'h0000_0100;
    irq = 3'b101;
    for (int i = 0; i < 13; i++) begin
      step();
      irq = 3'b000;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL priority cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_redirect) rpcs.push_back(s_rpc);
      if (s_we && s_waddr == 5'd13 && first_cause == 32'h0) first_cause = s_wdata;
    end
    n_checks += 3;
    if (rpcs.size() != 2) begin
      n_fail++; $display("FAIL priority_count: got %0d want 2", rpcs.size());
    end else begin
      if (rpcs[0] !== 32'h3000) begin n_fail++; $display("FAIL priority_first: got %h want 00003000", rpcs[0]); end
      if (rpcs[1] !== 32'h3020) begin n_fail++; $display("FAIL priority_second: got %h want 00003020", rpcs[1]); end
    end
    n_checks++;
    if (first_cause !== 32'h100) begin n_fail++; $display("FAIL priority_cause: got %h want 00000100", first_cause); end
  endtask

  task automatic test_ie_gate();
    int stalls = 0;
    int redirs = 0;
    ie = 1'b0; boundary = 1'b1;
    irq = 3'b001;
    for (int i = 0; i < 5; i++) begin
      step();
      irq = 3'b000;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL ie_gate cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_stall) stalls++;
    end
    n_checks += 2;
    if (stalls != 0) begin n_fail++; $display("FAIL ie_gate_stall: got %0d want 0", stalls); end
    if (pending !== 3'b001) begin n_fail++; $display("FAIL ie_gate_pending: got %b want 001", pending); end
    ie = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL ie_gate_take cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_redirect && s_rpc == 32'h3000) redirs++;
    end
    n_checks++;
    if (redirs != 1) begin n_fail++; $display("FAIL ie_gate_vector: got %0d want 1", redirs); end
  endtask

  task automatic test_eret();
    logic [31:0] rpcs[$];
    logic saw_raddr = 1'b0;
    logic saw_ie_one = 1'b0;
    ie = 1'b1; boundary = 1'b1; cp0_epc_tb = 32'h0000_0088;
    eret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      eret = 1'b0;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL eret cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_raddr == 5'd14) saw_raddr = 1'b1;
      if (s_ie_one && s_redirect) begin saw_ie_one = 1'b1; rpcs.push_back(s_rpc); end
    end
    n_checks += 2;
    if (!saw_raddr) begin n_fail++; $display("FAIL eret_raddr: got none want 14"); end
    if (!saw_ie_one || rpcs.size() != 1 || rpcs[0] !== 32'h88) begin
      n_fail++; $display("FAIL eret_redirect: got %0d redirects want one to 00000088", rpcs.size());
    end
    // eret coinciding with a take condition
    rpcs.delete();
    ie = 1'b0; irq = 3'b010;
    step(); irq = 3'b000;
    step();
    ie = 1'b1; eret = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      eret = 1'b0;
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL eret_vs_take cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (i == 0) begin
        n_checks++;
        if (s_stall !== 1'b0) begin n_fail++; $display("FAIL eret_first_stall: got %b want 0", s_stall); end
      end
      if (s_redirect) rpcs.push_back(s_rpc);
    end
    n_checks++;
    if (rpcs.size() != 2 || rpcs[0] !== 32'h88 || rpcs[1] !== 32'h3010) begin
      n_fail++; $display("FAIL eret_order: got %0d redirects first %h want 00000088 then 00003010",
                         rpcs.size(), (rpcs.size() > 0) ? rpcs[0] : 32'h0);
    end
  endtask

  task automatic test_reset_mid_mask();
    int redirs = 0;
    ie = 1'b1; boundary = 1'b1; pc_next = 32'h0000_0200;
    irq = 3'b100;
    step(); irq = 3'b000;
    step();  // take cycle
    step();  // SAVE_EPC
    step();  // now in MASK
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ie_one, ie_zero, stall, redirect, redirect_pc, pending} !== 82'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h want 0", {cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ie_one, ie_zero, stall, redirect, redirect_pc, pending});
    end
    model_reset();
    #2;
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL mid_reset_after cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_redirect || s_ie_zero) redirs++;
    end
    n_checks += 2;
    if (redirs != 0) begin n_fail++; $display("FAIL mid_reset_no_seq: got %0d want 0", redirs); end
    if (pending !== 3'b000) begin n_fail++; $display("FAIL mid_reset_pending: got %b want 000", pending); end
  endtask

  task automatic test_set_wins();
    int redirs = 0;
    ie = 1'b0; boundary = 1'b1;
    irq = 3'b010;
    step(); irq = 3'b000;
    step();
    ie = 1'b1; irq = 3'b010;
    step();
    n_checks++;
    if (s_stall !== 1'b1) begin n_fail++; $display("FAIL set_wins_take: got %b want 1", s_stall); end
    irq = 3'b000;
    step();
    n_checks++;
    if (s_pend !== 3'b010) begin n_fail++; $display("FAIL set_wins_pending: got %b want 010", s_pend); end
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL set_wins cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (s_redirect && s_rpc == 32'h3010) redirs++;
    end
    n_checks++;
    if (redirs != 2) begin n_fail++; $display("FAIL set_wins_services: got %0d want 2", redirs); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      irq        = 3'($urandom);
      boundary   = ($urandom_range(0, 3) != 0);
      ie         = ($urandom_range(0, 9) < 7);
      eret       = ($urandom_range(0, 15) == 0);
      pc_next    = $urandom;
      cp0_epc_tb = $urandom;
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
    end
    eret = 1'b0; irq = 3'b000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_n    = 1'b0;
    test_reset();
    test_single_irq();
    test_priority();
    test_ie_gate();
    test_eret();
    test_reset_mid_mask();
    test_set_wins();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
